// File: rtl/xm23_mem_pkg.sv
// Shared types and constants for the XM23 memory responder.
// Holds the handshake FSM states, the rw/bw encodings and the word-alignment rule.
package xm23_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      RESP
   } mem_state_t;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;
   localparam logic MEM_WORD  = 1'b0;
   localparam logic MEM_BYTE  = 1'b1;

   // Word accesses must sit on an even byte address; byte accesses may use either lane.
   function automatic logic isMisaligned(input logic bwSel, input logic addrLsb);
      return (bwSel == MEM_WORD) && addrLsb;
   endfunction

endpackage

// File: rtl/xm23_byte_bank.sv
// Single-port synchronous 8-bit RAM lane; write and read both happen on an enabled edge.
// Read-first: the read port returns the byte stored before any write on that same edge.
module xm23_byte_bank #(
   parameter int    DEPTH     = 32768,
   parameter int    AW        = 15,
   parameter string INIT_FILE = ""
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   // Enabled edge: commit the optional write and register the prior byte for the read port.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end
         rdata_o <= mem_q[addr_i];
      end
   end

endmodule

// File: rtl/xm23_mem_responder.sv
// Handshaked memory slave for the XM23 MAR/MDR bus: latches one request, waits,
// accesses the even/odd byte banks, then pulses ack with the result for one cycle.
module xm23_mem_responder
   import xm23_mem_pkg::*;
#(
   parameter int    ADDR_W      = 16,
   parameter int    DEPTH_WORDS = 32768,
   parameter int    WAIT_CYCLES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              req,
   input  logic              rw,
   input  logic              bw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       wdata,
   output logic [15:0]       rdata,
   output logic              ack,
   output logic              busy,
   output logic              err
);

   localparam int         IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   mem_state_t        state_q;
   logic [3:0]        waitCnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic              rw_q;
   logic              bw_q;
   logic              ack_q;
   logic              busy_q;
   logic              err_q;

   logic [IDX_W-1:0]  wordIdx;
   logic              misaligned;
   logic              bankEn;
   logic              weLo;
   logic              weHi;
   logic [7:0]        wdLo;
   logic [7:0]        wdHi;
   logic [7:0]        loDout;
   logic [7:0]        hiDout;

   // Upper address bits beyond the bank depth are dropped, so large addresses alias.
   assign wordIdx    = addr_q[IDX_W:1];
   assign misaligned = isMisaligned(bw_q, addr_q[0]);
   assign bankEn     = (state_q == ACCESS);

   // Lane decode: a word touches both banks, a byte only the lane picked by addr[0].
   always_comb begin
      weLo = 1'b0;
      weHi = 1'b0;
      wdLo = wdata_q[7:0];
      wdHi = wdata_q[15:8];
      if (bankEn && (rw_q == MEM_WRITE) && !misaligned) begin
         if (bw_q == MEM_WORD) begin
            weLo = 1'b1;
            weHi = 1'b1;
         end else begin
            weLo = ~addr_q[0];
            weHi = addr_q[0];
            wdHi = wdata_q[7:0];
         end
      end
   end

   xm23_byte_bank #(
      .DEPTH     (DEPTH_WORDS),
      .AW        (IDX_W),
      .INIT_FILE (INIT_FILE)
   ) u_bankLo (
      .clk_i   (Clock),
      .en_i    (bankEn),
      .we_i    (weLo),
      .addr_i  (wordIdx),
      .wdata_i (wdLo),
      .rdata_o (loDout)
   );

   xm23_byte_bank #(
      .DEPTH     (DEPTH_WORDS),
      .AW        (IDX_W),
      .INIT_FILE (INIT_FILE)
   ) u_bankHi (
      .clk_i   (Clock),
      .en_i    (bankEn),
      .we_i    (weHi),
      .addr_i  (wordIdx),
      .wdata_i (wdHi),
      .rdata_o (hiDout)
   );

   // Handshake FSM; ack, busy and err are registered here so they never glitch.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= IDLE;
         waitCnt_q <= 4'd0;
         addr_q    <= '0;
         wdata_q   <= 16'h0000;
         rw_q      <= MEM_READ;
         bw_q      <= MEM_WORD;
         ack_q     <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  rw_q    <= rw;
                  bw_q    <= bw;
                  busy_q  <= 1'b1;
                  if (WAIT_CYCLES > 0) begin
                     state_q   <= WAIT;
                     waitCnt_q <= WAIT_INIT;
                  end else begin
                     state_q <= ACCESS;
                  end
               end
            end
            WAIT: begin
               if (waitCnt_q <= 4'd1) begin
                  state_q   <= ACCESS;
                  waitCnt_q <= 4'd0;
               end else begin
                  waitCnt_q <= waitCnt_q - 4'd1;
               end
            end
            ACCESS: begin
               state_q <= RESP;
               ack_q   <= 1'b1;
               err_q   <= misaligned;
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               err_q   <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Bank outputs only hold meaningful data during the response cycle of a good read.
   always_comb begin
      rdata = 16'h0000;
      if (ack_q && !err_q && (rw_q == MEM_READ)) begin
         if (bw_q == MEM_BYTE) begin
            rdata = {8'h00, (addr_q[0] ? hiDout : loDout)};
         end else begin
            rdata = {hiDout, loDout};
         end
      end
   end

   assign ack  = ack_q;
   assign busy = busy_q;
   assign err  = err_q;

endmodule

// File: tb/tb_xm23_mem_responder.sv
// Directed bench for xm23_mem_responder: four instances cover wait states 0/1/7
// and a 16-word aliasing configuration; sel routes the shared request to one of them.
module tb_xm23_mem_responder;

   logic        clock;
   logic        resetn;
   logic        req;
   logic        rw;
   logic        bw;
   logic [15:0] addr;
   logic [15:0] wdata;
   int          sel;

   logic [3:0]  reqV;
   logic [3:0]  ackV;
   logic [3:0]  busyV;
   logic [3:0]  errV;
   logic [15:0] rdata0, rdata1, rdata2, rdata3;

   logic        curAck, curBusy, curErr;
   logic [15:0] curRdata;

   int checks;
   int failures;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instance map: 0 -> WAIT 0, 1 -> default, 2 -> WAIT 7, 3 -> 16-word depth.
   assign reqV[0] = req && (sel == 0);
   assign reqV[1] = req && (sel == 1);
   assign reqV[2] = req && (sel == 2);
   assign reqV[3] = req && (sel == 3);

   xm23_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
      .Clock(clock), .Resetn(resetn), .req(reqV[0]), .rw(rw), .bw(bw), .addr(addr),
      .wdata(wdata), .rdata(rdata0), .ack(ackV[0]), .busy(busyV[0]), .err(errV[0]));

   xm23_mem_responder u_dut1 (
      .Clock(clock), .Resetn(resetn), .req(reqV[1]), .rw(rw), .bw(bw), .addr(addr),
      .wdata(wdata), .rdata(rdata1), .ack(ackV[1]), .busy(busyV[1]), .err(errV[1]));

   xm23_mem_responder #(.WAIT_CYCLES(7)) u_dut7 (
      .Clock(clock), .Resetn(resetn), .req(reqV[2]), .rw(rw), .bw(bw), .addr(addr),
      .wdata(wdata), .rdata(rdata2), .ack(ackV[2]), .busy(busyV[2]), .err(errV[2]));

   xm23_mem_responder #(.DEPTH_WORDS(16)) u_dutW (
      .Clock(clock), .Resetn(resetn), .req(reqV[3]), .rw(rw), .bw(bw), .addr(addr),
      .wdata(wdata), .rdata(rdata3), .ack(ackV[3]), .busy(busyV[3]), .err(errV[3]));

   always_comb begin
      curAck   = ackV[1];
      curBusy  = busyV[1];
      curErr   = errV[1];
      curRdata = rdata1;
      case (sel)
         0: begin curAck = ackV[0]; curBusy = busyV[0]; curErr = errV[0]; curRdata = rdata0; end
         2: begin curAck = ackV[2]; curBusy = busyV[2]; curErr = errV[2]; curRdata = rdata2; end
         3: begin curAck = ackV[3]; curBusy = busyV[3]; curErr = errV[3]; curRdata = rdata3; end
         default: ;
      endcase
   end

   // One full transaction; inputs are scrambled right after acceptance to prove latching.
   task automatic applyStimulus(input logic rwv, input logic bwv, input logic [15:0] a,
                                input logic [15:0] wd, output int lat, output logic [15:0] rd,
                                output logic er, output logic busyOk);
      logic got;
      got    = 1'b0;
      lat    = 0;
      rd     = 16'h0000;
      er     = 1'b0;
      busyOk = 1'b1;
      @(negedge clock);
      rw    = rwv;
      bw    = bwv;
      addr  = a;
      wdata = wd;
      req   = 1'b1;
      for (int i = 0; i < 30 && !got; i++) begin
         @(posedge clock);
         lat++;
         #1;
         if (i == 0) begin
            req   = 1'b0;
            rw    = ~rwv;
            bw    = ~bwv;
            addr  = a ^ 16'hFFFF;
            wdata = ~wd;
         end
         @(negedge clock);
         if (curBusy !== 1'b1) busyOk = 1'b0;
         if (curAck === 1'b1) begin
            got = 1'b1;
            rd  = curRdata;
            er  = curErr;
         end
      end
      if (!got) begin
         lat = -1;
      end else begin
         @(posedge clock);
         @(negedge clock);
         if (curBusy !== 1'b0 || curAck !== 1'b0) busyOk = 1'b0;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      sel    = 1;
      repeat (3) @(negedge clock);
      checks++;
      if (ackV !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_ack: got %b expected 0000", ackV);
      end
      checks++;
      if (busyV !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_busy: got %b expected 0000", busyV);
      end
      checks++;
      if (errV !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_err: got %b expected 0000", errV);
      end
      checks++;
      if ((rdata0 | rdata1 | rdata2 | rdata3) !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL reset_rdata: got %h expected 0000", rdata1);
      end
      resetn = 1'b1;
   endtask

   task automatic test_word_rw();
      int lat; logic [15:0] rd; logic er, bok;
      sel = 1;
      applyStimulus(1'b1, 1'b0, 16'h0100, 16'hBEEF, lat, rd, er, bok);
      checks++;
      if (lat != 3 || er !== 1'b0 || bok !== 1'b1) begin
         failures++;
         $display("[TB] FAIL word_write: lat %0d err %b busy %b expected lat 3 err 0 busy 1", lat, er, bok);
      end
      applyStimulus(1'b0, 1'b0, 16'h0100, 16'h0000, lat, rd, er, bok);
      checks++;
      if (rd !== 16'hBEEF || er !== 1'b0) begin
         failures++;
         $display("[TB] FAIL word_read: got %h err %b expected BEEF err 0", rd, er);
      end
      checks++;
      if (lat != 3 || bok !== 1'b1) begin
         failures++;
         $display("[TB] FAIL word_read_timing: lat %0d busy %b expected lat 3 busy 1", lat, bok);
      end
   endtask

   task automatic test_byte_lanes();
      int lat; logic [15:0] rd; logic er, bok;
      sel = 1;
      applyStimulus(1'b1, 1'b0, 16'h0200, 16'h1234, lat, rd, er, bok);
      applyStimulus(1'b1, 1'b1, 16'h0201, 16'h77AB, lat, rd, er, bok);
      applyStimulus(1'b0, 1'b0, 16'h0200, 16'h0000, lat, rd, er, bok);
      checks++;
      if (rd !== 16'hAB34) begin
         failures++;
         $display("[TB] FAIL byte_lane_word_read: got %h expected AB34", rd);
      end
      applyStimulus(1'b0, 1'b1, 16'h0200, 16'h0000, lat, rd, er, bok);
      checks++;
      if (rd !== 16'h0034 || er !== 1'b0) begin
         failures++;
         $display("[TB] FAIL byte_read_even: got %h err %b expected 0034 err 0", rd, er);
      end
      applyStimulus(1'b0, 1'b1, 16'h0201, 16'h0000, lat, rd, er, bok);
      checks++;
      if (rd !== 16'h00AB || er !== 1'b0) begin
         failures++;
         $display("[TB] FAIL byte_read_odd: got %h err %b expected 00AB err 0", rd, er);
      end
   endtask

   task automatic test_misaligned();
      int lat; logic [15:0] rd; logic er, bok;
      sel = 1;
      applyStimulus(1'b1, 1'b0, 16'h0300, 16'h7766, lat, rd, er, bok);
      applyStimulus(1'b1, 1'b0, 16'h0301, 16'h5555, lat, rd, er, bok);
      checks++;
      if (er !== 1'b1 || rd !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL misaligned_write: err %b rdata %h expected err 1 rdata 0000", er, rd);
      end
      applyStimulus(1'b0, 1'b0, 16'h0301, 16'h0000, lat, rd, er, bok);
      checks++;
      if (er !== 1'b1 || rd !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL misaligned_read: err %b rdata %h expected err 1 rdata 0000", er, rd);
      end
      applyStimulus(1'b0, 1'b0, 16'h0300, 16'h0000, lat, rd, er, bok);
      checks++;
      if (rd !== 16'h7766 || er !== 1'b0) begin
         failures++;
         $display("[TB] FAIL misaligned_untouched: got %h err %b expected 7766 err 0", rd, er);
      end
   endtask

   task automatic test_wait_sweep();
      int lat; logic [15:0] rd; logic er, bok;
      int expLat [3];
      expLat[0] = 2;
      expLat[1] = 3;
      expLat[2] = 9;
      for (int k = 0; k < 3; k++) begin
         sel = k;
         applyStimulus(1'b1, 1'b0, 16'h0500, 16'hA0C0 + 16'(k), lat, rd, er, bok);
         checks++;
         if (lat != expLat[k] || bok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wait_sweep_write_%0d: lat %0d busy %b expected lat %0d busy 1", k, lat, bok, expLat[k]);
         end
         applyStimulus(1'b0, 1'b0, 16'h0500, 16'h0000, lat, rd, er, bok);
         checks++;
         if (lat != expLat[k] || bok !== 1'b1 || rd !== (16'hA0C0 + 16'(k))) begin
            failures++;
            $display("[TB] FAIL wait_sweep_read_%0d: lat %0d busy %b data %h expected lat %0d busy 1 data %h",
                     k, lat, bok, rd, expLat[k], 16'hA0C0 + 16'(k));
         end
      end
   endtask

   task automatic test_reset_mid_write();
      int lat; logic [15:0] rd; logic er, bok;
      sel = 1;
      applyStimulus(1'b1, 1'b0, 16'h0400, 16'h1111, lat, rd, er, bok);
      @(negedge clock);
      rw = 1'b1; bw = 1'b0; addr = 16'h0400; wdata = 16'hFFFF; req = 1'b1;
      @(posedge clock);
      #1;
      req    = 1'b0;
      resetn = 1'b0;
      @(negedge clock);
      checks++;
      if (curAck !== 1'b0 || curBusy !== 1'b0 || curErr !== 1'b0 || curRdata !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL reset_hold_outputs: ack %b busy %b err %b rdata %h expected all 0",
                  curAck, curBusy, curErr, curRdata);
      end
      @(negedge clock);
      resetn = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0400, 16'h0000, lat, rd, er, bok);
      checks++;
      if (rd !== 16'h1111) begin
         failures++;
         $display("[TB] FAIL reset_before_access: got %h expected 1111", rd);
      end
      applyStimulus(1'b1, 1'b0, 16'h0402, 16'h3333, lat, rd, er, bok);
      @(negedge clock);
      rw = 1'b1; bw = 1'b0; addr = 16'h0402; wdata = 16'h2222; req = 1'b1;
      @(posedge clock);
      #1 req = 1'b0;
      repeat (2) @(posedge clock);
      #1 resetn = 1'b0;
      @(negedge clock);
      checks++;
      if (curAck !== 1'b0 || curBusy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_in_resp: ack %b busy %b expected 0 0", curAck, curBusy);
      end
      resetn = 1'b1;
      applyStimulus(1'b0, 1'b0, 16'h0402, 16'h0000, lat, rd, er, bok);
      checks++;
      if (rd !== 16'h2222) begin
         failures++;
         $display("[TB] FAIL reset_after_access: got %h expected 2222", rd);
      end
   endtask

   task automatic test_back_to_back();
      int ackCount;
      ackCount = 0;
      sel = 1;
      @(negedge clock);
      rw = 1'b0; bw = 1'b0; addr = 16'h0100; wdata = 16'h0000; req = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clock);
         @(negedge clock);
         if (curAck === 1'b1) ackCount++;
         if (n == 3) begin
            checks++;
            if (curAck !== 1'b1 || curRdata !== 16'hBEEF) begin
               failures++;
               $display("[TB] FAIL b2b_first: ack %b data %h expected ack 1 data BEEF", curAck, curRdata);
            end
            addr = 16'h0200;
         end
         if (n == 4) begin
            checks++;
            if (curAck !== 1'b0 || curBusy !== 1'b0) begin
               failures++;
               $display("[TB] FAIL b2b_idle_gap: ack %b busy %b expected 0 0", curAck, curBusy);
            end
         end
         if (n == 7) begin
            checks++;
            if (curAck !== 1'b1 || curRdata !== 16'hAB34) begin
               failures++;
               $display("[TB] FAIL b2b_second: ack %b data %h expected ack 1 data AB34", curAck, curRdata);
            end
            req = 1'b0;
         end
      end
      checks++;
      if (ackCount != 2) begin
         failures++;
         $display("[TB] FAIL b2b_ack_count: got %0d expected 2", ackCount);
      end
   endtask

   task automatic test_wrap();
      int lat; logic [15:0] rd; logic er, bok;
      sel = 3;
      applyStimulus(1'b1, 1'b0, 16'h0020, 16'hCAFE, lat, rd, er, bok);
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, lat, rd, er, bok);
      checks++;
      if (rd !== 16'hCAFE) begin
         failures++;
         $display("[TB] FAIL wrap_alias_low: got %h expected CAFE", rd);
      end
      applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0BAD, lat, rd, er, bok);
      applyStimulus(1'b0, 1'b0, 16'h0020, 16'h0000, lat, rd, er, bok);
      checks++;
      if (rd !== 16'h0BAD) begin
         failures++;
         $display("[TB] FAIL wrap_alias_high: got %h expected 0BAD", rd);
      end
   endtask

   task automatic checkOutput();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      resetn   = 1'b0;
      req      = 1'b0;
      rw       = 1'b0;
      bw       = 1'b0;
      addr     = 16'h0000;
      wdata    = 16'h0000;
      sel      = 1;
      test_reset();
      test_word_rw();
      test_byte_lanes();
      test_misaligned();
      test_wait_sweep();
      test_reset_mid_write();
      test_back_to_back();
      test_wrap();
      checkOutput();
      $finish;
   end

endmodule
